// File: rtl/hwjsoc_oci_pkg.sv
// Shared types and constants for the OCI debug-RAM arbiter.
package hwjsoc_oci_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_ACC  = 2'd1,
    JTAG_ACC = 2'd2
  } state_e;

  localparam int JDO_ADDR_LSB = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam logic [1:0] WP_REGION = 2'b11;

  // Requester indices into req/gnt; last_grant holds one of these.
  localparam int REQ_CPU  = 0;
  localparam int REQ_JTAG = 1;

endpackage

// File: rtl/hwjsoc_cpu_e_ocimem_arbiter_if.sv
// Avalon debug-slave bus between the CPU_E master and the OCI RAM arbiter.
interface hwjsoc_cpu_e_ocimem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [3:0]        av_byteenable;
  logic [DATA_W-1:0] av_readdata;
  logic              av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/hwjsoc_oci_rr_arb2.sv
// Two-requester round-robin: on a tie the side that did not win last time is granted.
module hwjsoc_oci_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_grant != 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/hwjsoc_cpu_e_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the CPU_E Avalon slave and JTAG commands.
// Optional HWJSOC_OCIMEM_CPU_WP_EN: CPU writes to the top quarter of the RAM are suppressed.
module hwjsoc_cpu_e_ocimem_arbiter
  import hwjsoc_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  hwjsoc_cpu_e_ocimem_arbiter_if.slave av,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  state_e            state_q, state_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic              jtag_wr_q, jtag_wr_d;
  logic [DATA_W-1:0] jtag_wdata_q, jtag_wdata_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              last_grant_q, last_grant_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] mon_q, mon_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       wp_hit;
  logic       wp_block;
  logic       unused_ok;

  assign req[REQ_CPU]  = (state_q == IDLE) & (av.av_read | av.av_write);
  assign req[REQ_JTAG] = (state_q == IDLE) & jtag_pend_q;

  hwjsoc_oci_rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign wp_hit = (av.av_address[ADDR_W-1 -: 2] == WP_REGION);
`ifdef HWJSOC_OCIMEM_CPU_WP_EN
  assign wp_block  = wp_hit;
  assign unused_ok = ^{jdo[37:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0]};
`else
  assign wp_block  = 1'b0;
  assign unused_ok = ^{jdo[37:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0], wp_hit};
`endif

  always_comb begin
    state_d      = state_q;
    jtag_pend_d  = jtag_pend_q;
    jtag_wr_d    = jtag_wr_q;
    jtag_wdata_d = jtag_wdata_q;
    jtag_addr_d  = jtag_addr_q;
    last_grant_d = last_grant_q;
    overrun_d    = overrun_q;
    mon_d        = mon_q;
    ram_addr     = av.av_address;
    ram_we       = 1'b0;
    ram_be       = av.av_byteenable;
    ram_wdata    = av.av_writedata;

    case (state_q)
      IDLE: begin
        if (gnt[REQ_CPU]) begin
          ram_we       = av.av_write & ~wp_block & ~reset;
          last_grant_d = 1'(REQ_CPU);
          state_d      = CPU_ACC;
        end else if (gnt[REQ_JTAG]) begin
          ram_addr     = jtag_addr_q;
          ram_we       = jtag_wr_q & ~reset;
          ram_be       = 4'hF;
          ram_wdata    = jtag_wdata_q;
          last_grant_d = 1'(REQ_JTAG);
          state_d      = JTAG_ACC;
        end
      end
      CPU_ACC: state_d = IDLE;
      JTAG_ACC: begin
        if (!jtag_wr_q) mon_d = ram_rdata;
        jtag_pend_d = 1'b0;
        jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes arriving while a command is still pending (including its access cycle) are lost.
    if (take_action_ocimem_a) begin
      if (!jtag_pend_q) jtag_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
      overrun_d = take_no_action_ocimem_a | take_action_ocimem_b;
    end else if (take_no_action_ocimem_a | take_action_ocimem_b) begin
      if (jtag_pend_q) begin
        overrun_d = 1'b1;
      end else begin
        jtag_pend_d  = 1'b1;
        jtag_wr_d    = take_action_ocimem_b;
        jtag_wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
        if (take_no_action_ocimem_a & take_action_ocimem_b) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_wdata_q <= '0;
      jtag_addr_q  <= '0;
      last_grant_q <= 1'(REQ_CPU);
      overrun_q    <= 1'b0;
      mon_q        <= '0;
    end else begin
      state_q      <= state_d;
      jtag_pend_q  <= jtag_pend_d;
      jtag_wr_q    <= jtag_wr_d;
      jtag_wdata_q <= jtag_wdata_d;
      jtag_addr_q  <= jtag_addr_d;
      last_grant_q <= last_grant_d;
      overrun_q    <= overrun_d;
      mon_q        <= mon_d;
    end
  end

  assign av.av_waitrequest = (state_q != CPU_ACC);
  assign av.av_readdata    = ram_rdata;
  assign MonDReg           = mon_q;
  assign monitor_ready     = ~jtag_pend_q;
  assign jtag_overrun      = overrun_q;

endmodule

// File: tb/tb_hwjsoc_cpu_e_ocimem_arbiter.sv
// Self-checking bench: directed scenarios plus random CPU/JTAG traffic against a shadow-memory model.
`timescale 1ns/1ps
module tb_hwjsoc_cpu_e_ocimem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          s_a, s_nb, s_b;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata, MonDReg;
  logic          monitor_ready, jtag_overrun;

  always #5 clk = ~clk;

  hwjsoc_cpu_e_ocimem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) av_if ();

  hwjsoc_cpu_e_ocimem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (s_a),
    .take_no_action_ocimem_a (s_nb),
    .take_action_ocimem_b    (s_b),
    .av                      (av_if),
    .ram_addr                (ram_addr),
    .ram_we                  (ram_we),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  // External single-port RAM, one-cycle read latency.
  logic [DW-1:0] ram_mem [0:255];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) ram_mem[ram_addr][8*i +: 8] = ram_wdata[8*i +: 8];
  end

  // Reference model: which requester owns the current two-cycle RAM slot, plus shadow memory.
  int            m_owner;   // 0 none, 1 CPU completing this cycle, 2 JTAG completing this cycle
  bit            m_pend, m_pwr, m_last, m_ovr, m_cpu_rd;
  logic [DW-1:0] m_pdata, m_mon, m_jread, m_cpu_exp;
  logic [AW-1:0] m_jaddr;
  logic [DW-1:0] shadow [0:255];

  int checks = 0;
  int errors = 0;

  logic          obs_wait, obs_we, obs_ready, obs_ovr;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_rdata, obs_mon;
  bit            cpu_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] jdo_addr(input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_data(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_pend = 0; m_pwr = 0; m_last = 0; m_ovr = 0;
    m_mon = '0; m_jaddr = '0; m_cpu_rd = 0;
  endtask

  task automatic model_cycle();
    bit            cpu_r, cpu_w, g_cpu, g_jt, wp, exp_we, pend0;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [3:0]    exp_be;
    cpu_r = av_if.av_read | av_if.av_write;
    cpu_w = av_if.av_write;
    g_cpu = 0; g_jt = 0; exp_we = 0;
    exp_addr = '0; exp_wd = '0; exp_be = '0;
    if (m_owner == 0) begin
      if (cpu_r && m_pend) begin
        if (m_last) g_cpu = 1; else g_jt = 1;
      end else if (cpu_r) g_cpu = 1;
      else if (m_pend) g_jt = 1;
    end
    wp = 0;
`ifdef HWJSOC_OCIMEM_CPU_WP_EN
    wp = (av_if.av_address >= 8'hC0);
`endif
    if (g_cpu) begin
      exp_addr = av_if.av_address; exp_we = cpu_w && !wp && !reset;
      exp_wd = av_if.av_writedata; exp_be = av_if.av_byteenable;
    end
    if (g_jt) begin
      exp_addr = m_jaddr; exp_we = m_pwr && !reset; exp_wd = m_pdata; exp_be = 4'hF;
    end

    chk("waitrequest", av_if.av_waitrequest, m_owner != 1);
    chk("monitor_ready", monitor_ready, !m_pend);
    chk("jtag_overrun", jtag_overrun, m_ovr);
    chk("MonDReg", MonDReg, m_mon);
    if (m_owner == 1 && m_cpu_rd) chk("av_readdata", av_if.av_readdata, m_cpu_exp);
    chk("ram_we", ram_we, exp_we);
    if (g_cpu || g_jt) chk("ram_addr", ram_addr, exp_addr);
    if (exp_we) begin
      chk("ram_wdata", ram_wdata, exp_wd);
      chk("ram_be", ram_be, exp_be);
    end

    if (reset) begin
      model_reset();
      return;
    end
    pend0 = m_pend;
    if (m_owner == 2) begin
      m_pend = 0;
      if (!m_pwr) m_mon = m_jread;
      m_jaddr = m_jaddr + 8'd1;
    end
    m_owner = g_cpu ? 1 : (g_jt ? 2 : 0);
    if (g_cpu) begin
      m_last = 0;
      m_cpu_rd = !cpu_w;
      m_cpu_exp = shadow[exp_addr];
      if (exp_we)
        for (int i = 0; i < 4; i++)
          if (exp_be[i]) shadow[exp_addr][8*i +: 8] = exp_wd[8*i +: 8];
    end
    if (g_jt) begin
      m_last = 1;
      if (m_pwr) shadow[exp_addr] = exp_wd;
      else m_jread = shadow[exp_addr];
    end
    if (s_a) begin
      if (!pend0) m_jaddr = jdo[24:17];
      m_ovr = s_nb | s_b;
    end else if (s_nb | s_b) begin
      if (pend0) m_ovr = 1;
      else begin
        m_pend = 1; m_pwr = s_b; m_pdata = jdo[34:3];
      end
    end
  endtask

  // One clock: settle, compare against the model, advance it, then retire strobes/completed requests.
  task automatic step();
    #1;
    obs_wait = av_if.av_waitrequest; obs_we = ram_we; obs_ready = monitor_ready;
    obs_ovr = jtag_overrun; obs_addr = ram_addr; obs_rdata = av_if.av_readdata; obs_mon = MonDReg;
    model_cycle();
    cpu_done = (av_if.av_waitrequest === 1'b0);
    @(negedge clk);
    s_a = 0; s_nb = 0; s_b = 0;
    if (cpu_done) begin
      av_if.av_read = 0;
      av_if.av_write = 0;
    end
  endtask

  task automatic cpu_set(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    av_if.av_read = rd; av_if.av_write = wr; av_if.av_address = a;
    av_if.av_writedata = d; av_if.av_byteenable = be;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] saved;
    int r;
    reset = 1; s_a = 0; s_nb = 0; s_b = 0; jdo = '0;
    cpu_set(0, 0, 8'h00, 32'h0, 4'hF);
    for (int a = 0; a < 256; a++) ram_mem[a] = $urandom;
    ram_mem[5] = 32'hDEADBEEF;
    ram_mem[8'hC0] = 32'h0BADF00D;
    for (int a = 0; a < 256; a++) shadow[a] = ram_mem[a];
    @(negedge clk); @(negedge clk);
    model_reset();

    // Reset values, with a CPU write presented during reset.
    cpu_set(0, 1, 8'h10, 32'hFFFF0000, 4'hF);
    step();
    chk("reset_ram_we", obs_we, 1'b0);
    chk("reset_waitrequest", obs_wait, 1'b1);
    chk("reset_monitor_ready", obs_ready, 1'b1);
    chk("reset_overrun", obs_ovr, 1'b0);
    chk("reset_MonDReg", obs_mon, 32'h0);
    av_if.av_write = 0; reset = 0;

    // CPU read of address 5 completes in the second cycle.
    cpu_set(1, 0, 8'h05, 32'h0, 4'hF);
    step();
    chk("t1_wait_cycle1", obs_wait, 1'b1);
    step();
    chk("t1_wait_cycle2", obs_wait, 1'b0);
    chk("t1_readdata", obs_rdata, 32'hDEADBEEF);

    // JTAG writes at FF then wrap to 00.
    s_a = 1; jdo = jdo_addr(8'hFF); step();
    s_b = 1; jdo = jdo_data(32'h1); step();
    step();
    chk("t2_ready_low", obs_ready, 1'b0);
    step();
    s_b = 1; jdo = jdo_data(32'h2); step();
    chk("t2_ready_high", obs_ready, 1'b1);
    step(); step(); step();
    chk("t2_ram_ff", ram_mem[8'hFF], 32'h1);
    chk("t2_ram_00", ram_mem[8'h00], 32'h2);

    // Tie after reset goes to JTAG, then CPU; after a JTAG-only access the next tie goes to CPU.
    reset = 1; step(); reset = 0;
    s_nb = 1; step();
    cpu_set(1, 0, 8'h33, 32'h0, 4'hF); step();
    chk("t3_tie1_jtag", obs_addr, 8'h00);
    step();
    step();
    chk("t3_cpu_after", obs_addr, 8'h33);
    step();
    chk("t3_cpu_done", obs_wait, 1'b0);
    s_nb = 1; step();
    step();
    chk("t3_jtag_alone", obs_addr, 8'h01);
    step();
    s_nb = 1; step();
    cpu_set(1, 0, 8'h44, 32'h0, 4'hF); step();
    chk("t3_tie2_cpu", obs_addr, 8'h44);
    step();
    step();
    chk("t3_jtag_after", obs_addr, 8'h02);
    step(); step();

    // Second write strobe while pending is dropped and flags overrun; ocimem_a clears it.
    s_b = 1; jdo = jdo_data(32'h12345678); step();
    s_b = 1; jdo = jdo_data(32'h55555555); step();
    step();
    chk("t4_overrun_set", obs_ovr, 1'b1);
    step();
    s_a = 1; jdo = jdo_addr(8'h10); step();
    step();
    chk("t4_overrun_clr", obs_ovr, 1'b0);
    chk("t4_ram_03", ram_mem[8'h03], 32'h12345678);

    // Reset during a CPU write grant cycle.
    saved = ram_mem[8'h20];
    cpu_set(0, 1, 8'h20, 32'hCAFEF00D, 4'hF); reset = 1;
    step();
    chk("t5_ram_we", obs_we, 1'b0);
    av_if.av_write = 0; reset = 0;
    step();
    chk("t5_waitrequest", obs_wait, 1'b1);
    chk("t5_monitor_ready", obs_ready, 1'b1);
    chk("t5_overrun", obs_ovr, 1'b0);
    chk("t5_MonDReg", obs_mon, 32'h0);
    chk("t5_ram_unchanged", ram_mem[8'h20], saved);

`ifdef HWJSOC_OCIMEM_CPU_WP_EN
    cpu_set(0, 1, 8'hC0, 32'h11112222, 4'hF); step();
    step();
    chk("t6_cpu_done", obs_wait, 1'b0);
    step();
    chk("t6_cpu_blocked", ram_mem[8'hC0], 32'h0BADF00D);
    s_a = 1; jdo = jdo_addr(8'hC0); step();
    s_b = 1; jdo = jdo_data(32'h33334444); step();
    step(); step(); step();
    chk("t6_jtag_write", ram_mem[8'hC0], 32'h33334444);
`endif

    // Random mixed traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!(av_if.av_read || av_if.av_write) && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 3);
        cpu_set(r < 2, r >= 2, 8'($urandom), $urandom, 4'($urandom));
      end
      jdo = {6'($urandom), 32'($urandom)};
      r = $urandom_range(0, 9);
      s_a  = (r == 0) || (r == 3);
      s_nb = (r == 1);
      s_b  = (r == 2) || (r == 3);
      step();
    end
    cpu_set(0, 0, 8'h00, 32'h0, 4'hF);
    step(); step(); step(); step();

    for (int a = 0; a < 256; a++) chk("ram_final", ram_mem[a], shadow[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
